cgra_tile_config_rx: RTL and testbench
======================================

// Module: cgra_tile_config_rx
// PURPOSE
//  Tile-side receiver for the CGRA configuration bus. Every cycle it samples config_addr_in/config_data_in as driven by the
//  bitstream loader, decodes tile/feature/register fields and writes matching words into shadow registers. Shadow words
//  are committed to the active config outputs, which feed the tile's PE/switch-box muxes.
//  Address 32'h0 is the bus idle code (loader drives it after the last bitstream line); tile ID 0 is therefore reserved.
// PARAMETERS
//  TILE_ID            16'h0001  tile address matched against addr[15:0]; must be nonzero
//  NUM_FEATURES       4         features per tile, feature IDs 0..NUM_FEATURES-1
//  NUM_REGS           8         32-bit registers per feature, reg IDs 0..NUM_REGS-1
//  IDLE_COMMIT_CYCLES 4         consecutive idle-bus cycles that trigger auto-commit (>=1)
// PORTS
//  clk_in            in   1                      clock, all logic on rising edge
//  reset_in          in   1                      synchronous, active-high reset
//  config_addr_in    in   32                     [15:0] tile, [23:16] feature, [31:24] reg; 0 = idle
//  config_data_in    in   32                     write data, valid in the same cycle as the address
//  cfg_active_out    out  NUM_FEATURES*NUM_REGS*32  committed registers, feature f reg r at index (f*NUM_REGS+r)*32
//  config_state_out  out  2                      0 UNCONFIGURED, 1 CONFIGURING, 2 ACTIVE
//  commit_pulse_out  out  1                      one-cycle pulse in the cycle after a commit
//  err_count_out     out  8                      saturating count of out-of-range writes to this tile
//  read_data_out     out  32                     present only with CFG_READBACK_EN
// BEHAVIOUR
//  Reset: shadow, active, err_count, idle counter, read_data_out all 0; state UNCONFIGURED; commit_pulse_out 0.
//  Write: addr!=0 and tile==TILE_ID, feature<NUM_FEATURES, reg<NUM_REGS -> shadow[f][r] <= data at next edge.
//  Out-of-range feature/reg (not the commit code) with matching tile -> no write, err_count+1, saturating at 8'hFF.
//  Commit code: tile match, feature 8'hFF, reg 8'hFF -> shadow copied to active at next edge; data ignored; not an error.
//  Idle counter: increments on addr==0 in CONFIGURING, clears on any nonzero addr, held at 0 outside CONFIGURING.
//  Auto-commit fires in the cycle where the counter would reach IDLE_COMMIT_CYCLES; counter then clears.
//  FSM: UNCONFIGURED -valid write-> CONFIGURING; CONFIGURING -commit-> ACTIVE; ACTIVE -valid write-> CONFIGURING.
//  Explicit commit accepted from UNCONFIGURED (copies zero shadow) and from ACTIVE; both go to ACTIVE and pulse.
//  Active registers change only on commit; the ACTIVE->CONFIGURING write leaves active outputs untouched.
//  Commit takes effect on the edge after the commit cycle; commit_pulse_out high for exactly that following cycle.
//  Other-tile addresses: no effect except clearing the idle counter. Reset mid-configuration discards shadow and active.
// CONFIGURATION
//  CFG_READBACK_EN defined: read_data_out <= shadow[f][r] one cycle after a tile-matching in-range address.
//   Otherwise read_data_out <= 0. The read coincides with any write in that cycle and returns the pre-write value.
//  CFG_READBACK_EN undefined: read_data_out port and readback mux are absent; all other behaviour is identical.
// STRUCTURE
//  cgra_config_pkg: state enum, field LSB/width constants (TILE 0/16, FEAT 16/8, REG 24/8), COMMIT_FEAT/REG=8'hFF,
//   IDLE_ADDR=32'h0.
//  Sub-module cgra_config_addr_decode (combinational): splits the address and produces
//   is_idle, tile_hit, in_range, is_commit, flat index.
//  Top level holds the shadow/active arrays, FSM, idle counter, error counter and optional readback register.
// TESTING
//  1 Reset, write (tile1,f0,r0)=32'hDEADBEEF, then commit code -> state 1 then 2, pulse 1 cycle, active[0]=DEADBEEF.
//  2 Write f2 r5=32'h0000_00A5, drive addr 0 for 4 cycles -> auto-commit on 4th idle edge, active[(2*8+5)]=A5.
//  3 Write f2 r5 after ACTIVE -> state 1, active still A5 until commit; idle 3 cycles then other-tile addr -> no commit.
//  4 Write tile1 f7 r0 and f0 r9 -> no shadow change, err_count=2; 300 such writes -> err_count=8'hFF.
//  5 Write tile2 data -> no change, state stays UNCONFIGURED; reset_in in CONFIGURING -> all outputs 0, state 0.
//  6 CFG_READBACK_EN: write f1 r3=32'h1234 then address it -> read_data_out=32'h1234 one cycle later.

Source files
------------

// File: rtl/cgra_config_pkg.sv
// rtl/cgra_config_pkg.sv - state encoding and address-field layout for the CGRA tile config receiver
package cgra_config_pkg;

   typedef enum logic [1:0] {
      ST_UNCONFIGURED = 2'd0,
      ST_CONFIGURING  = 2'd1,
      ST_ACTIVE       = 2'd2
   } cfg_state_e;

   localparam int unsigned TILE_LSB = 0;
   localparam int unsigned TILE_W   = 16;
   localparam int unsigned FEAT_LSB = 16;
   localparam int unsigned FEAT_W   = 8;
   localparam int unsigned REG_LSB  = 24;
   localparam int unsigned REG_W    = 8;

   localparam logic [FEAT_W-1:0] COMMIT_FEAT = 8'hFF;
   localparam logic [REG_W-1:0]  COMMIT_REG  = 8'hFF;
   localparam logic [31:0]       IDLE_ADDR   = 32'h0;

   function automatic int unsigned idx_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/cgra_config_addr_decode.sv
// rtl/cgra_config_addr_decode.sv - combinational split of a config-bus address into tile/feature/register terms
module cgra_config_addr_decode
   import cgra_config_pkg::*;
#(
   parameter logic [15:0] TILE_ID      = 16'h0001,
   parameter int unsigned NUM_FEATURES = 4,
   parameter int unsigned NUM_REGS     = 8,
   parameter int unsigned IDX_W        = idx_width(NUM_FEATURES * NUM_REGS)
) (
   input  logic [31:0]      addr_i,
   output logic             is_idle_o,
   output logic             tile_hit_o,
   output logic             in_range_o,
   output logic             is_commit_o,
   output logic [IDX_W-1:0] idx_o
);

   logic [TILE_W-1:0] tile;
   logic [FEAT_W-1:0] feat;
   logic [REG_W-1:0]  regn;

   always_comb begin
      tile        = addr_i[TILE_LSB +: TILE_W];
      feat        = addr_i[FEAT_LSB +: FEAT_W];
      regn        = addr_i[REG_LSB +: REG_W];
      is_idle_o   = (addr_i == IDLE_ADDR);
      // TILE_ID is never 0, so the idle code can never look like a hit.
      tile_hit_o  = !is_idle_o && (tile == TILE_ID);
      in_range_o  = (32'(feat) < NUM_FEATURES) && (32'(regn) < NUM_REGS);
      is_commit_o = (feat == COMMIT_FEAT) && (regn == COMMIT_REG);
      idx_o       = IDX_W'(32'(feat) * NUM_REGS + 32'(regn));
   end

endmodule

// File: rtl/cgra_tile_config_rx.sv
// rtl/cgra_tile_config_rx.sv - tile-side config bus receiver: shadow/active registers, commit FSM, idle auto-commit
// Optional readback port and mux are built only when CFG_READBACK_EN is defined.
module cgra_tile_config_rx
   import cgra_config_pkg::*;
#(
   parameter logic [15:0] TILE_ID            = 16'h0001,
   parameter int unsigned NUM_FEATURES       = 4,
   parameter int unsigned NUM_REGS           = 8,
   parameter int unsigned IDLE_COMMIT_CYCLES = 4
) (
   input  logic                                 clk_in,
   input  logic                                 reset_in,
   input  logic [31:0]                          config_addr_in,
   input  logic [31:0]                          config_data_in,
   output logic [NUM_FEATURES*NUM_REGS*32-1:0]  cfg_active_out,
   output logic [1:0]                           config_state_out,
   output logic                                 commit_pulse_out,
   output logic [7:0]                           err_count_out
`ifdef CFG_READBACK_EN
   ,
   output logic [31:0]                          read_data_out
`endif
);

   localparam int unsigned NUM_WORDS = NUM_FEATURES * NUM_REGS;
   localparam int unsigned IDX_W     = idx_width(NUM_WORDS);
   localparam int unsigned CNT_W     = idx_width(IDLE_COMMIT_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(IDLE_COMMIT_CYCLES - 1);

   logic             is_idle, tile_hit, in_range, is_commit;
   logic [IDX_W-1:0] idx;

   cgra_config_addr_decode #(
      .TILE_ID      (TILE_ID),
      .NUM_FEATURES (NUM_FEATURES),
      .NUM_REGS     (NUM_REGS),
      .IDX_W        (IDX_W)
   ) u_decode (
      .addr_i      (config_addr_in),
      .is_idle_o   (is_idle),
      .tile_hit_o  (tile_hit),
      .in_range_o  (in_range),
      .is_commit_o (is_commit),
      .idx_o       (idx)
   );

   logic [NUM_WORDS-1:0][31:0] shadow_q;
   logic [NUM_WORDS-1:0][31:0] active_q;
   cfg_state_e                 state_q, state_d;
   logic [CNT_W-1:0]           idle_cnt_q, idle_cnt_d;
   logic [7:0]                 err_cnt_q;
   logic                       commit_pulse_q;

   logic wr_en, err_hit, auto_commit, commit;

   assign wr_en   = tile_hit && in_range;
   assign err_hit = tile_hit && !in_range && !is_commit;

   always_comb begin
      state_d     = state_q;
      idle_cnt_d  = '0;
      auto_commit = 1'b0;
      // The counter fires on the cycle it would reach the threshold, so it never holds that value.
      if (state_q == ST_CONFIGURING && is_idle) begin
         if (idle_cnt_q == CNT_LAST) begin
            auto_commit = 1'b1;
         end else begin
            idle_cnt_d = idle_cnt_q + CNT_W'(1);
         end
      end
      commit = auto_commit || (tile_hit && is_commit);
      if (commit) begin
         state_d = ST_ACTIVE;
      end else if (wr_en) begin
         state_d = ST_CONFIGURING;
      end
   end

   always_ff @(posedge clk_in) begin
      if (reset_in) begin
         state_q <= ST_UNCONFIGURED;
      end else begin
         state_q <= state_d;
      end
   end

   always_ff @(posedge clk_in) begin
      if (reset_in) begin
         shadow_q       <= '0;
         active_q       <= '0;
         idle_cnt_q     <= '0;
         err_cnt_q      <= '0;
         commit_pulse_q <= 1'b0;
      end else begin
         idle_cnt_q     <= idle_cnt_d;
         commit_pulse_q <= commit;
         if (wr_en) begin
            shadow_q[idx] <= config_data_in;
         end
         if (commit) begin
            active_q <= shadow_q;
         end
         if (err_hit && err_cnt_q != 8'hFF) begin
            err_cnt_q <= err_cnt_q + 8'd1;
         end
      end
   end

   assign cfg_active_out   = active_q;
   assign config_state_out = state_q;
   assign commit_pulse_out = commit_pulse_q;
   assign err_count_out    = err_cnt_q;

`ifdef CFG_READBACK_EN
   logic [31:0] read_q;

   // Samples shadow before any same-cycle write lands, so a write returns the old word.
   always_ff @(posedge clk_in) begin
      if (reset_in) begin
         read_q <= '0;
      end else begin
         read_q <= wr_en ? shadow_q[idx] : 32'h0;
      end
   end

   assign read_data_out = read_q;
`endif

endmodule

// File: tb/tb_cgra_tile_config_rx.sv
// tb/tb_cgra_tile_config_rx.sv - self-checking bench for cgra_tile_config_rx against an array-based reference model
module tb_cgra_tile_config_rx;

   localparam int TILE = 1;
   localparam int NF   = 4;
   localparam int NR   = 8;
   localparam int NW   = NF * NR;
   localparam int IDLE = 4;

   logic              clk_in = 1'b0;
   logic              reset_in = 1'b1;
   logic [31:0]       config_addr_in = 32'h0;
   logic [31:0]       config_data_in = 32'h0;
   logic [NW*32-1:0]  cfg_active_out;
   logic [1:0]        config_state_out;
   logic              commit_pulse_out;
   logic [7:0]        err_count_out;
`ifdef CFG_READBACK_EN
   logic [31:0]       read_data_out;
`endif

   cgra_tile_config_rx #(
      .TILE_ID            (16'h0001),
      .NUM_FEATURES       (NF),
      .NUM_REGS           (NR),
      .IDLE_COMMIT_CYCLES (IDLE)
   ) dut (
      .clk_in           (clk_in),
      .reset_in         (reset_in),
      .config_addr_in   (config_addr_in),
      .config_data_in   (config_data_in),
      .cfg_active_out   (cfg_active_out),
      .config_state_out (config_state_out),
      .commit_pulse_out (commit_pulse_out),
      .err_count_out    (err_count_out)
`ifdef CFG_READBACK_EN
      ,
      .read_data_out    (read_data_out)
`endif
   );

   always #5 clk_in = ~clk_in;

   int n_cmp = 0;
   int n_bad = 0;

   logic [31:0] sh_m [NW];
   logic [31:0] act_m [NW];
   int          st_m, err_m, idle_m;
   logic        pulse_m;
   logic [31:0] rd_m;

   task automatic model_reset();
      for (int i = 0; i < NW; i++) begin
         sh_m[i]  = 32'h0;
         act_m[i] = 32'h0;
      end
      st_m = 0; err_m = 0; idle_m = 0; pulse_m = 1'b0; rd_m = 32'h0;
   endtask

   // One bus cycle as the specification describes it, with plain integers and arrays.
   task automatic model_step(input logic [31:0] a, input logic [31:0] d);
      int t, f, r;
      bit cm;
      t = int'(a[15:0]); f = int'(a[23:16]); r = int'(a[31:24]);
      cm = 0;
      rd_m = 32'h0;
      if (a == 32'h0) begin
         if (st_m == 1) begin
            idle_m++;
            if (idle_m == IDLE) begin cm = 1; idle_m = 0; end
         end else begin
            idle_m = 0;
         end
      end else begin
         idle_m = 0;
         if (t == TILE) begin
            if (f == 255 && r == 255) cm = 1;
            else if (f < NF && r < NR) begin
               rd_m = sh_m[f*NR + r];
               sh_m[f*NR + r] = d;
               st_m = 1;
            end else if (err_m < 255) err_m++;
         end
      end
      if (cm) begin
         for (int i = 0; i < NW; i++) act_m[i] = sh_m[i];
         st_m = 2;
      end
      pulse_m = cm;
   endtask

   function automatic logic [NW*32-1:0] exp_active();
      logic [NW*32-1:0] v;
      for (int i = 0; i < NW; i++) v[i*32 +: 32] = act_m[i];
      return v;
   endfunction

   function automatic logic [31:0] mk(input int f, input int r, input int t);
      return {r[7:0], f[7:0], t[15:0]};
   endfunction

   task automatic step(input logic [31:0] a, input logic [31:0] d);
      config_addr_in = a;
      config_data_in = d;
      @(posedge clk_in);
      model_step(a, d);
      #1;
   endtask

   task automatic do_reset();
      reset_in = 1'b1;
      config_addr_in = 32'h0;
      config_data_in = 32'h0;
      @(posedge clk_in);
      model_reset();
      #1;
      reset_in = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      n_cmp++; if (config_state_out !== 2'd0) begin n_bad++; $display("FAIL reset_state got %0d want 0", config_state_out); end
      n_cmp++; if (cfg_active_out !== '0) begin n_bad++; $display("FAIL reset_active got %h want 0", cfg_active_out); end
      n_cmp++; if (commit_pulse_out !== 1'b0) begin n_bad++; $display("FAIL reset_pulse got %b want 0", commit_pulse_out); end
      n_cmp++; if (err_count_out !== 8'h0) begin n_bad++; $display("FAIL reset_err got %0d want 0", err_count_out); end
   endtask

   task automatic test_explicit_commit();
      step(mk(0, 0, 1), 32'hDEADBEEF);
      n_cmp++; if (config_state_out !== 2'd1) begin n_bad++; $display("FAIL wr_state got %0d want 1", config_state_out); end
      n_cmp++; if (cfg_active_out[31:0] !== 32'h0) begin n_bad++; $display("FAIL wr_active0 got %h want 0", cfg_active_out[31:0]); end
      step(32'hFFFF_0001, 32'h1111_2222);
      n_cmp++; if (config_state_out !== 2'd2) begin n_bad++; $display("FAIL commit_state got %0d want 2", config_state_out); end
      n_cmp++; if (commit_pulse_out !== 1'b1) begin n_bad++; $display("FAIL commit_pulse got %b want 1", commit_pulse_out); end
      n_cmp++; if (cfg_active_out[31:0] !== 32'hDEADBEEF) begin n_bad++; $display("FAIL commit_active0 got %h want deadbeef", cfg_active_out[31:0]); end
      step(32'h0, 32'h0);
      n_cmp++; if (commit_pulse_out !== 1'b0) begin n_bad++; $display("FAIL pulse_width got %b want 0", commit_pulse_out); end
   endtask

   task automatic test_auto_commit();
      step(mk(2, 5, 1), 32'h0000_00A5);
      for (int i = 0; i < IDLE - 1; i++) step(32'h0, 32'h0);
      n_cmp++; if (config_state_out !== 2'd1 || commit_pulse_out !== 1'b0) begin
         n_bad++; $display("FAIL auto_early got state %0d pulse %b want 1/0", config_state_out, commit_pulse_out); end
      step(32'h0, 32'h0);
      n_cmp++; if (config_state_out !== 2'd2 || commit_pulse_out !== 1'b1) begin
         n_bad++; $display("FAIL auto_fire got state %0d pulse %b want 2/1", config_state_out, commit_pulse_out); end
      n_cmp++; if (cfg_active_out[(2*NR+5)*32 +: 32] !== 32'hA5) begin
         n_bad++; $display("FAIL auto_active got %h want a5", cfg_active_out[(2*NR+5)*32 +: 32]); end
   endtask

   task automatic test_idle_interrupted();
      step(mk(2, 5, 1), 32'h0000_0077);
      n_cmp++; if (config_state_out !== 2'd1 || cfg_active_out[(2*NR+5)*32 +: 32] !== 32'hA5) begin
         n_bad++; $display("FAIL reconf got state %0d active %h want 1/a5", config_state_out, cfg_active_out[(2*NR+5)*32 +: 32]); end
      for (int i = 0; i < IDLE - 1; i++) step(32'h0, 32'h0);
      step(32'h0000_0002, 32'hFFFF_FFFF);
      for (int i = 0; i < IDLE - 1; i++) step(32'h0, 32'h0);
      n_cmp++; if (config_state_out !== 2'd1 || commit_pulse_out !== 1'b0) begin
         n_bad++; $display("FAIL idle_cleared got state %0d pulse %b want 1/0", config_state_out, commit_pulse_out); end
      step(32'h0, 32'h0);
      n_cmp++; if (config_state_out !== 2'd2 || cfg_active_out[(2*NR+5)*32 +: 32] !== 32'h77) begin
         n_bad++; $display("FAIL idle_recommit got state %0d active %h want 2/77", config_state_out, cfg_active_out[(2*NR+5)*32 +: 32]); end
   endtask

   task automatic test_errors();
      do_reset();
      step(mk(7, 0, 1), 32'hAAAA_AAAA);
      step(mk(0, 9, 1), 32'hBBBB_BBBB);
      n_cmp++; if (err_count_out !== 8'd2) begin n_bad++; $display("FAIL err_two got %0d want 2", err_count_out); end
      n_cmp++; if (config_state_out !== 2'd0) begin n_bad++; $display("FAIL err_state got %0d want 0", config_state_out); end
      step(32'hFFFF_0001, 32'h0);
      n_cmp++; if (cfg_active_out !== '0 || err_count_out !== 8'd2) begin
         n_bad++; $display("FAIL err_nowrite got active %h err %0d want 0/2", cfg_active_out, err_count_out); end
      for (int i = 0; i < 300; i++) step(mk(4 + (i % 200), i % 256, 1), 32'h5);
      n_cmp++; if (err_count_out !== 8'hFF) begin n_bad++; $display("FAIL err_sat got %0d want 255", err_count_out); end
   endtask

   task automatic test_other_tile_reset();
      do_reset();
      step(mk(1, 1, 2), 32'h1234_5678);
      n_cmp++; if (config_state_out !== 2'd0) begin n_bad++; $display("FAIL other_tile got state %0d want 0", config_state_out); end
      step(mk(1, 1, 1), 32'h1234_5678);
      step(32'hFFFF_0001, 32'h0);
      step(mk(3, 7, 1), 32'h9);
      n_cmp++; if (config_state_out !== 2'd1) begin n_bad++; $display("FAIL pre_reset got state %0d want 1", config_state_out); end
      do_reset();
      n_cmp++; if (config_state_out !== 2'd0 || cfg_active_out !== '0 || commit_pulse_out !== 1'b0 || err_count_out !== 8'd0) begin
         n_bad++; $display("FAIL mid_reset got state %0d pulse %b err %0d want 0/0/0", config_state_out, commit_pulse_out, err_count_out); end
      step(32'hFFFF_0001, 32'h0);
      n_cmp++; if (cfg_active_out !== '0 || config_state_out !== 2'd2) begin
         n_bad++; $display("FAIL reset_shadow got state %0d active %h want 2/0", config_state_out, cfg_active_out); end
   endtask

`ifdef CFG_READBACK_EN
   task automatic test_readback();
      step(mk(1, 3, 1), 32'h0000_1234);
      step(mk(1, 3, 1), 32'h0000_9999);
      n_cmp++; if (read_data_out !== 32'h1234) begin n_bad++; $display("FAIL readback got %h want 1234", read_data_out); end
      step(32'h0, 32'h0);
      n_cmp++; if (read_data_out !== 32'h0) begin n_bad++; $display("FAIL readback_idle got %h want 0", read_data_out); end
   endtask
`endif

   task automatic test_random();
      logic [31:0] a;
      int sel, f, r, t;
      do_reset();
      for (int n = 0; n < 600; n++) begin
         sel = $urandom_range(0, 11);
         if (sel <= 3) a = 32'h0;
         else if (sel <= 6) a = mk($urandom_range(0, NF-1), $urandom_range(0, NR-1), TILE);
         else if (sel == 7) begin
            f = $urandom_range(NF, 255); r = $urandom_range(0, 255);
            if (f == 255 && r == 255) r = 0;
            a = ($urandom_range(0, 1) == 0) ? mk(f, r, TILE) : mk($urandom_range(0, NF-1), $urandom_range(NR, 255), TILE);
         end
         else if (sel == 8) a = 32'hFFFF_0001;
         else if (sel == 9) begin
            t = $urandom_range(0, 65535);
            if (t == TILE) t = 2;
            a = mk($urandom_range(0, 255), $urandom_range(0, 255), t);
         end
         else a = $urandom;
         if (n == 300) do_reset();
         step(a, $urandom);
         n_cmp++; if (config_state_out !== st_m[1:0]) begin n_bad++; $display("FAIL rnd_state cyc %0d got %0d want %0d", n, config_state_out, st_m); end
         n_cmp++; if (commit_pulse_out !== pulse_m) begin n_bad++; $display("FAIL rnd_pulse cyc %0d got %b want %b", n, commit_pulse_out, pulse_m); end
         n_cmp++; if (err_count_out !== err_m[7:0]) begin n_bad++; $display("FAIL rnd_err cyc %0d got %0d want %0d", n, err_count_out, err_m); end
         n_cmp++; if (cfg_active_out !== exp_active()) begin n_bad++; $display("FAIL rnd_active cyc %0d got %h want %h", n, cfg_active_out, exp_active()); end
`ifdef CFG_READBACK_EN
         n_cmp++; if (read_data_out !== rd_m) begin n_bad++; $display("FAIL rnd_read cyc %0d got %h want %h", n, read_data_out, rd_m); end
`endif
      end
   endtask

   initial begin
      model_reset();
      test_reset();
      test_explicit_commit();
      test_auto_commit();
      test_idle_interrupted();
      test_errors();
      test_other_tile_reset();
`ifdef CFG_READBACK_EN
      test_readback();
`endif
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
